// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch FSM states, IF/ID record layout
// and fetch-related constants used by the front end and decode.
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

  // IF/ID record: {instruction[63:32], pc_plus4[31:0]}
  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc_plus4;
  } if_id_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry IF/ID skid buffer: catches a word acknowledged while decode is
// stalled so the memory handshake can complete without losing it.
module fetch_skid_buffer
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   i_load,
  input  logic   i_clear,
  input  if_id_t i_data,
  output if_id_t o_data,
  output logic   o_valid
);

  if_id_t r_data;
  logic   r_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch front end: owns the PC, the req/ack imem port and the
// IF/ID register with stall, flush and EX redirect.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = mips_pkg::DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_Stall,
  input  logic        in_Redirect,
  input  logic [31:0] in_RedirectPC_32,
  output logic        o_ImemReq,
  output logic [31:0] o_ImemAddr_32,
  input  logic        in_ImemAck,
  input  logic [31:0] in_ImemData_32,
  output logic [31:0] o_Instruction_32,
  output logic [31:0] o_PCPlus4_32,
  output logic        o_Valid
);

  mips_pkg::fetch_state_t r_state, w_state_next;
  mips_pkg::if_id_t       r_if_id, w_if_id_next;
  mips_pkg::if_id_t       w_skid_data;
  mips_pkg::if_id_t       w_bubble;
  logic [31:0]            r_pc, w_pc_next;
  logic [31:0]            r_req_addr, w_req_addr_next;
  logic [31:0]            w_pc_plus4;
  logic [31:0]            w_redirect_pc;
  logic                   r_valid, w_valid_next;
  logic                   w_req;
  logic                   w_skid_load, w_skid_clear, w_skid_valid;

  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_redirect_pc = mips_pkg::align_word(in_RedirectPC_32);
  assign w_bubble      = '{instruction: NOP_WORD, pc_plus4: 32'd0};

  fetch_skid_buffer u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  ('{instruction: in_ImemData_32, pc_plus4: w_pc_plus4}),
    .o_data  (w_skid_data),
    .o_valid (w_skid_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= mips_pkg::FETCH;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_if_id    <= w_bubble;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_req_addr <= w_req_addr_next;
      r_if_id    <= w_if_id_next;
      r_valid    <= w_valid_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_req_addr_next = r_req_addr;
    w_if_id_next    = r_if_id;
    w_valid_next    = r_valid;
    w_req           = 1'b0;
    o_ImemAddr_32   = r_pc;
    w_skid_load     = 1'b0;
    w_skid_clear    = 1'b0;

    case (r_state)
      mips_pkg::FETCH: begin
        w_req = 1'b1;
        if (in_Redirect) begin
          w_pc_next    = w_redirect_pc;
          w_if_id_next = w_bubble;
          w_valid_next = 1'b0;
          // Request still in flight: remember its address so it stays stable until acked.
          if (!in_ImemAck) begin
            w_req_addr_next = r_pc;
            w_state_next    = mips_pkg::DISCARD;
          end
        end else if (in_ImemAck && in_Stall) begin
          w_skid_load  = 1'b1;
          w_pc_next    = w_pc_plus4;
          w_state_next = mips_pkg::HOLD;
        end else if (in_ImemAck) begin
          w_if_id_next = '{instruction: in_ImemData_32, pc_plus4: w_pc_plus4};
          w_valid_next = 1'b1;
          w_pc_next    = w_pc_plus4;
        end else if (!in_Stall) begin
          w_if_id_next = w_bubble;
          w_valid_next = 1'b0;
        end
      end

      mips_pkg::HOLD: begin
        if (in_Redirect) begin
          w_skid_clear = 1'b1;
          w_pc_next    = w_redirect_pc;
          w_if_id_next = w_bubble;
          w_valid_next = 1'b0;
          w_state_next = mips_pkg::FETCH;
        end else if (!in_Stall) begin
          w_skid_clear = 1'b1;
          w_if_id_next = w_skid_data;
          w_valid_next = w_skid_valid;
          w_state_next = mips_pkg::FETCH;
        end
      end

      mips_pkg::DISCARD: begin
        w_req         = 1'b1;
        o_ImemAddr_32 = r_req_addr;
        if (in_Redirect) begin
          w_pc_next    = w_redirect_pc;
          w_if_id_next = w_bubble;
          w_valid_next = 1'b0;
        end else if (!in_Stall) begin
          w_if_id_next = w_bubble;
          w_valid_next = 1'b0;
        end
        if (in_ImemAck) begin
          w_state_next = mips_pkg::FETCH;
        end
      end

      default: begin
        w_state_next = mips_pkg::FETCH;
      end
    endcase
  end

  assign o_ImemReq        = w_req & ~reset;
  assign o_Instruction_32 = r_if_id.instruction;
  assign o_PCPlus4_32     = r_if_id.pc_plus4;
  assign o_Valid          = r_valid;

endmodule
